// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the shared-ALU arbiter slice.
//   f3OpInt      : RV32I integer funct3 encodings (OP / OP-IMM)
//   F7_ZERO/ALT  : funct7 values accepted by the integer alu
//   alu_illegal  : encoding legality check for one operation
//   alu_exec     : the combinational integer alu (RV32 semantics)
package alu_share_arb_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SL   = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } f3OpInt;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Returns 1 for encodings the alu cannot execute.
    function automatic logic alu_illegal(input logic       op,
                                         input logic       op_imm,
                                         input logic [2:0] f3,
                                         input logic [6:0] f7);
        logic bad;
        logic f7_ok;
        f7_ok = (f7 == F7_ZERO) || (f7 == F7_ALT);
        bad   = (op == op_imm);
        case (f3)
            F3_ADD:  if (op && !f7_ok) bad = 1'b1;
            F3_SL:   if (f7 != F7_ZERO) bad = 1'b1;
            F3_SR:   if (!f7_ok) bad = 1'b1;
            default: if (op && (f7 != F7_ZERO)) bad = 1'b1;
        endcase
        return bad;
    endfunction

    // sub : OP-class ADD with F7_ALT (SUB); sra : SR with F7_ALT.
    // Shift amounts arrive already masked to 5 bits.
    function automatic logic [ALU_W-1:0] alu_exec(input logic             sub,
                                                  input logic             sra,
                                                  input logic [2:0]       f3,
                                                  input logic [ALU_W-1:0] a,
                                                  input logic [ALU_W-1:0] b);
        logic [ALU_W-1:0] r;
        r = '0;
        case (f3)
            F3_ADD:  r = sub ? (a - b) : (a + b);
            F3_SL:   r = a << b[4:0];
            F3_SLT:  r = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
            F3_SLTU: r = {{(ALU_W-1){1'b0}}, (a < b)};
            F3_XOR:  r = a ^ b;
            F3_SR:   r = sra ? ALU_W'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            F3_OR:   r = a | b;
            F3_AND:  r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_share_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requesting index found
// scanning ptr, ptr+1, ... wrapping modulo N_REQ.
//   req   in  N_REQ   request vector
//   ptr   in  PW      highest-priority index this cycle
//   grant out N_REQ   one-hot (or zero) grant
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational integer alu among N_REQ requesters. One operation
// is granted per cycle (round robin); its result lands in that requester's
// one-entry response slot on the next cycle.
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     request handshake per requester (ready = grant)
//   req_op/req_op_imm       instruction class per requester
//   req_funct3/req_funct7   packed 3/7-bit fields, slice i at [3i+:3]/[7i+:7]
//   req_a/req_b             packed XLEN operands per requester
//   rsp_valid/rsp_ready     response slot handshake per requester
//   rsp_data/rsp_err        packed result; err flags an illegal encoding (data 0)
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ-1:0]      req_op,
    input  logic [N_REQ-1:0]      req_op_imm,
    input  logic [3*N_REQ-1:0]    req_funct3,
    input  logic [7*N_REQ-1:0]    req_funct7,
    input  logic [XLEN*N_REQ-1:0] req_a,
    input  logic [XLEN*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [XLEN*N_REQ-1:0] rsp_data,
    output logic [N_REQ-1:0]      rsp_err
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gidx;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant;

    logic             s_op, s_op_imm;
    logic [2:0]       s_f3;
    logic [6:0]       s_f7;
    logic [XLEN-1:0]  s_a, s_b, s_b_cond, s_res;
    logic             s_err;

    // A full slot only blocks its own requester, and only until it drains.
    // Gating with rst_n keeps req_ready low for the whole reset.
    assign elig = req_valid & (~rsp_valid | rsp_ready) & {N_REQ{rst_n}};

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req   (elig),
        .ptr   (ptr),
        .grant (grant)
    );

    assign req_ready = grant;

    // One-hot AND-OR mux onto the shared alu inputs.
    always_comb begin
        s_op     = 1'b0;
        s_op_imm = 1'b0;
        s_f3     = '0;
        s_f7     = '0;
        s_a      = '0;
        s_b      = '0;
        gidx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            s_op     = s_op     | (grant[i] & req_op[i]);
            s_op_imm = s_op_imm | (grant[i] & req_op_imm[i]);
            s_f3     = s_f3     | ({3{grant[i]}} & req_funct3[3*i +: 3]);
            s_f7     = s_f7     | ({7{grant[i]}} & req_funct7[7*i +: 7]);
            s_a      = s_a      | ({XLEN{grant[i]}} & req_a[XLEN*i +: XLEN]);
            s_b      = s_b      | ({XLEN{grant[i]}} & req_b[XLEN*i +: XLEN]);
            if (grant[i]) gidx = PW'(i);
        end
    end

    // Shifts only see the low five bits; this also strips imm[10] (the SRAI
    // marker) from an OP-IMM shift immediate.
    always_comb begin
        s_b_cond = s_b;
        if (s_f3 == F3_SL || s_f3 == F3_SR) s_b_cond = {{(XLEN-5){1'b0}}, s_b[4:0]};
    end

    assign s_err = alu_illegal(s_op, s_op_imm, s_f3, s_f7);
    assign s_res = alu_exec(s_op && (s_f7 == F7_ALT),
                            (s_f7 == F7_ALT),
                            s_f3, s_a, s_b_cond);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= '0;
        end else begin
            if (|grant) ptr <= (gidx == PW'(N_REQ-1)) ? '0 : gidx + 1'b1;
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i]) begin
                    // Fill wins over a same-cycle drain: slot stays full with new data.
                    rsp_valid[i]                <= 1'b1;
                    rsp_err[i]                  <= s_err;
                    rsp_data[XLEN*i +: XLEN]    <= s_err ? '0 : s_res;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;

    localparam int N = 2;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_op = '0;
    logic [N-1:0]   req_op_imm = '0;
    logic [3*N-1:0] req_funct3 = '0;
    logic [7*N-1:0] req_funct7 = '0;
    logic [W*N-1:0] req_a = '0;
    logic [W*N-1:0] req_b = '0;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '0;
    logic [W*N-1:0] rsp_data;
    logic [N-1:0]   rsp_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.N_REQ(N), .XLEN(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_op_imm(req_op_imm),
        .req_funct3(req_funct3), .req_funct7(req_funct7),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    typedef struct {
        logic        op;
        logic        op_imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    task automatic set_req(input int i, input logic op, input logic op_imm,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b);
        req_op[i]           = op;
        req_op_imm[i]       = op_imm;
        req_funct3[3*i +: 3] = f3;
        req_funct7[7*i +: 7] = f7;
        req_a[W*i +: W]     = a;
        req_b[W*i +: W]     = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        set_req(0, 1, 0, 3'd0, 7'd0, 32'd1, 32'd1);
        #1;
        n_vec++;
        if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        n_vec++;
        if (rsp_valid !== 2'b00 || rsp_err !== 2'b00 || rsp_data !== '0) begin
            n_bad++; $display("FAIL reset_state valid=%b err=%b data=%h exp all 0", rsp_valid, rsp_err, rsp_data);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        @(negedge clk);
        req_valid = 2'b01; rsp_ready = 2'b00;
        set_req(0, 1, 0, 3'd0, 7'd0, 32'd5, 32'd7);
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        n_vec++;
        if (rsp_valid[0] !== 1'b1 || rsp_data[31:0] !== 32'd12 || rsp_err[0] !== 1'b0) begin
            n_bad++; $display("FAIL single_add v=%b d=%h e=%b exp v=1 d=0000000c e=0", rsp_valid[0], rsp_data[31:0], rsp_err[0]);
        end
        @(negedge clk);
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        n_vec++;
        if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL single_drain got=%b exp=00", rsp_valid); end
        rsp_ready = 2'b00;
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g;
        do_reset();
        @(negedge clk);
        req_valid = 2'b11; rsp_ready = 2'b11;
        set_req(0, 1, 0, 3'd0, 7'h00, 32'd1, 32'd2);   // 1+2
        set_req(1, 1, 0, 3'd0, 7'h20, 32'd10, 32'd3);  // 10-3
        for (int c = 0; c < 4; c++) begin
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            n_vec++;
            if (req_ready !== exp_g) begin n_bad++; $display("FAIL alt_grant c=%0d got=%b exp=%b", c, req_ready, exp_g); end
            @(posedge clk); #1;
            n_vec++;
            if (rsp_valid !== exp_g ||
                (exp_g[0] && rsp_data[31:0] !== 32'd3) || (exp_g[1] && rsp_data[63:32] !== 32'd7)) begin
                n_bad++; $display("FAIL alt_rsp c=%0d v=%b d=%h exp v=%b", c, rsp_valid, rsp_data, exp_g);
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        n_vec++;
        if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL alt_drain got=%b exp=00", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 2'b01; rsp_ready = 2'b01;
        for (int c = 1; c <= 4; c++) begin
            set_req(0, 1, 0, 3'd0, 7'd0, 32'(c * 100), 32'(c));
            @(posedge clk); #1;
            n_vec++;
            if (rsp_valid[0] !== 1'b1 || rsp_data[31:0] !== 32'(c * 101)) begin
                n_bad++; $display("FAIL b2b c=%0d v=%b d=%0d exp v=1 d=%0d", c, rsp_valid[0], rsp_data[31:0], c * 101);
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_encodings();
        vec_t tbl[19];
        tbl[0]  = '{1, 0, 3'd0, 7'h01, 32'd5,         32'd7,         32'h0,         1'b1}; // ADD bad f7
        tbl[1]  = '{1, 1, 3'd0, 7'h00, 32'd5,         32'd7,         32'h0,         1'b1}; // op & op_imm
        tbl[2]  = '{0, 0, 3'd0, 7'h00, 32'd5,         32'd7,         32'h0,         1'b1}; // neither
        tbl[3]  = '{1, 0, 3'd1, 7'h01, 32'd1,         32'd1,         32'h0,         1'b1}; // SLL bad f7
        tbl[4]  = '{0, 1, 3'd1, 7'h20, 32'd1,         32'd1,         32'h0,         1'b1}; // SLLI f7 alt
        tbl[5]  = '{0, 1, 3'd5, 7'h01, 32'd1,         32'd1,         32'h0,         1'b1}; // SRI bad f7
        tbl[6]  = '{1, 0, 3'd4, 7'h20, 32'd1,         32'd1,         32'h0,         1'b1}; // XOR f7!=0
        tbl[7]  = '{0, 1, 3'd4, 7'h20, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 1'b0}; // XORI
        tbl[8]  = '{1, 0, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0}; // SLT -1<1
        tbl[9]  = '{1, 0, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0}; // SLTU
        tbl[10] = '{1, 0, 3'd1, 7'h00, 32'd1,         32'd33,        32'd2,         1'b0}; // SLL shamt 1
        tbl[11] = '{1, 0, 3'd5, 7'h00, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0}; // SRL
        tbl[12] = '{1, 0, 3'd5, 7'h20, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0}; // SRA
        tbl[13] = '{0, 1, 3'd5, 7'h20, 32'h8000_0000, 32'h0000_0404, 32'hF800_0000, 1'b0}; // SRAI
        tbl[14] = '{1, 0, 3'd0, 7'h20, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0}; // SUB wrap
        tbl[15] = '{0, 1, 3'd0, 7'h7F, 32'd1,         32'hFFFF_FFFF, 32'h0,         1'b0}; // ADDI wrap
        tbl[16] = '{1, 0, 3'd7, 7'h00, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b0}; // AND
        tbl[17] = '{1, 0, 3'd6, 7'h00, 32'h0000_00F0, 32'h0000_003C, 32'h0000_00FC, 1'b0}; // OR
        tbl[18] = '{1, 0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'd1,         32'h0,         1'b0}; // ADD wrap
        @(negedge clk);
        req_valid = 2'b01; rsp_ready = 2'b01;
        for (int k = 0; k < 19; k++) begin
            set_req(0, tbl[k].op, tbl[k].op_imm, tbl[k].f3, tbl[k].f7, tbl[k].a, tbl[k].b);
            @(posedge clk); #1;
            n_vec++;
            if (rsp_valid[0] !== 1'b1 || rsp_data[31:0] !== tbl[k].exp_d || rsp_err[0] !== tbl[k].exp_e) begin
                n_bad++;
                $display("FAIL enc%0d v=%b d=%h e=%b exp v=1 d=%h e=%b", k, rsp_valid[0],
                         rsp_data[31:0], rsp_err[0], tbl[k].exp_d, tbl[k].exp_e);
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        req_valid = 2'b01; rsp_ready = 2'b00;
        set_req(0, 1, 0, 3'd0, 7'd0, 32'd40, 32'd2);
        set_req(1, 1, 0, 3'd0, 7'd0, 32'd50, 32'd3);
        @(posedge clk); #1;                            // slot0 full, ptr=1
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        n_vec++;
        if (req_ready !== 2'b10) begin n_bad++; $display("FAIL bp_grant1 got=%b exp=10", req_ready); end
        @(posedge clk); #1;                            // slot1 full, ptr=0
        @(negedge clk);
        rsp_ready = 2'b10;
        #1;
        n_vec++;
        if (req_ready !== 2'b10) begin n_bad++; $display("FAIL bp_grant2 got=%b exp=10", req_ready); end
        @(posedge clk); #1;
        n_vec++;
        if (rsp_valid !== 2'b11 || rsp_data[31:0] !== 32'd42 || rsp_data[63:32] !== 32'd53) begin
            n_bad++; $display("FAIL bp_hold v=%b d=%h exp v=11 d=00000035_0000002a", rsp_valid, rsp_data);
        end
        @(negedge clk);
        rsp_ready = 2'b11;
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_release got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 2'b01; rsp_ready = 2'b00;
        set_req(0, 1, 0, 3'd0, 7'd0, 32'd9, 32'd9);
        @(posedge clk); #1;                            // slot0 full, ptr=1
        @(negedge clk);
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (rsp_valid !== 2'b00 || rsp_data !== '0 || req_ready !== 2'b00) begin
            n_bad++; $display("FAIL midrst v=%b d=%h rdy=%b exp all 0", rsp_valid, rsp_data, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin n_bad++; $display("FAIL midrst_first got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_alternate();
        test_back_to_back();
        test_encodings();
        test_backpressure();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout sim_time=%0t exp finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
